// File: rtl/vga_pkg.sv
// Shared VGA types: per-axis timing description, standard mode presets,
// and the bundle of control signals that travels alongside pixel data.
package vga_pkg;

   typedef struct packed {
      int unsigned visible;
      int unsigned fp;
      int unsigned sync;
      int unsigned bp;
   } vga_timing_t;

   typedef struct packed {
      vga_timing_t h;
      vga_timing_t v;
   } vga_mode_t;

   localparam vga_mode_t VGA_800x600_56 = '{h: '{800, 24, 72, 128}, v: '{600, 1, 2, 22}};
   localparam vga_mode_t VGA_640x480_60 = '{h: '{640, 16, 96, 48},  v: '{480, 10, 2, 33}};

   // Control signals that must stay cycle-aligned with the pixel data.
   typedef struct packed {
      logic de;
      logic h_sync;
      logic v_sync;
      logic frame_start;
      logic line_start;
   } vga_ctrl_t;

   localparam int unsigned CTRL_W = $bits(vga_ctrl_t);

   function automatic int unsigned vga_total(input vga_timing_t t);
      return t.visible + t.fp + t.sync + t.bp;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enabled shift register of DEPTH stages; DEPTH=0 is a plain wire.
// Every stage resets to RST_VAL so the tap starts out idle.
module vga_delay_line #(
   parameter int unsigned      WIDTH   = 1,
   parameter int unsigned      DEPTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   if (DEPTH == 0) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = &{1'b0, clk, rst, ce};
      assign dout          = din;
   end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
         for (int i = 0; i < int'(DEPTH); i++) stage_d[i] = stage_q[i];
         if (ce) begin
            stage_d[0] = din;
            for (int i = 1; i < int'(DEPTH); i++) stage_d[i] = stage_q[i-1];
         end
      end

      // NOTE: every stage is reset, not just the last; otherwise stale
      // control bits would ripple out for DEPTH cycles after reset.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= RST_VAL;
         end else begin
            for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= stage_d[i];
         end
      end

      assign dout = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/vga_display_engine.sv
// VGA raster engine: scans the frame, issues pixel read addresses and aligns
// sync/de/pulses with the returned data. Build macro VGA_TEST_PATTERN_EN adds colour bars.
module vga_display_engine
   import vga_pkg::*;
#(
   parameter int unsigned H_VISIBLE  = VGA_800x600_56.h.visible,
   parameter int unsigned H_FP       = VGA_800x600_56.h.fp,
   parameter int unsigned H_SYNC     = VGA_800x600_56.h.sync,
   parameter int unsigned H_BP       = VGA_800x600_56.h.bp,
   parameter int unsigned V_VISIBLE  = VGA_800x600_56.v.visible,
   parameter int unsigned V_FP       = VGA_800x600_56.v.fp,
   parameter int unsigned V_SYNC     = VGA_800x600_56.v.sync,
   parameter int unsigned V_BP       = VGA_800x600_56.v.bp,
   parameter logic        H_POL      = 1'b0,
   parameter logic        V_POL      = 1'b0,
   parameter int unsigned R_W        = 3,
   parameter int unsigned G_W        = 3,
   parameter int unsigned B_W        = 2,
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned X_W        = 10,
   parameter int unsigned Y_W        = 10,
   localparam int unsigned PIX_W     = R_W + G_W + B_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ce,
`ifdef VGA_TEST_PATTERN_EN
   input  logic                 test_en,
`endif
   input  logic [PIX_W-1:0]     data,
   output logic [X_W+Y_W-1:0]   addr,
   output logic                 addr_valid,
   output logic                 h_sync,
   output logic                 v_sync,
   output logic                 de,
   output logic [R_W-1:0]       red,
   output logic [G_W-1:0]       green,
   output logic [B_W-1:0]       blue,
   output logic                 frame_start,
   output logic                 line_start
);

   localparam vga_timing_t H_TIM   = '{H_VISIBLE, H_FP, H_SYNC, H_BP};
   localparam vga_timing_t V_TIM   = '{V_VISIBLE, V_FP, V_SYNC, V_BP};
   localparam int unsigned H_TOTAL = vga_total(H_TIM);
   localparam int unsigned V_TOTAL = vga_total(V_TIM);
   localparam int unsigned H_BITS  = $clog2(H_TOTAL);
   localparam int unsigned V_BITS  = $clog2(V_TOTAL);
   localparam int unsigned XC_W    = (H_BITS > X_W) ? H_BITS : X_W;
   localparam int unsigned YC_W    = (V_BITS > Y_W) ? V_BITS : Y_W;

   localparam logic [XC_W-1:0] X_LAST   = XC_W'(H_TOTAL - 1);
   localparam logic [XC_W-1:0] X_VIS    = XC_W'(H_VISIBLE);
   localparam logic [XC_W-1:0] HS_BEG   = XC_W'(H_VISIBLE + H_FP);
   localparam logic [XC_W-1:0] HS_END   = XC_W'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [YC_W-1:0] Y_LAST   = YC_W'(V_TOTAL - 1);
   localparam logic [YC_W-1:0] Y_VIS    = YC_W'(V_VISIBLE);
   localparam logic [YC_W-1:0] VS_BEG   = YC_W'(V_VISIBLE + V_FP);
   localparam logic [YC_W-1:0] VS_END   = YC_W'(V_VISIBLE + V_FP + V_SYNC);

   localparam vga_ctrl_t CTRL_IDLE = '{de: 1'b0, h_sync: ~H_POL, v_sync: ~V_POL,
                                       frame_start: 1'b0, line_start: 1'b0};

   if (H_VISIBLE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_VISIBLE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
       H_VISIBLE > 2**X_W || V_VISIBLE > 2**Y_W || RD_LATENCY > 7) begin : g_bad_params
      $error("vga_display_engine: illegal timing or width parameters");
   end

   logic [XC_W-1:0] x_q, x_d;
   logic [YC_W-1:0] y_q, y_d;

   // NOTE: every output of an always_comb gets a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (ce) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops
   // update together from pre-edge values, independent of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   logic      h_vis, v_vis;
   vga_ctrl_t ctrl_now, ctrl_dly;

   always_comb begin
      h_vis                = (x_q < X_VIS);
      v_vis                = (y_q < Y_VIS);
      addr_valid           = h_vis & v_vis;
      addr                 = addr_valid ? {y_q[Y_W-1:0], x_q[X_W-1:0]} : '0;
      ctrl_now.de          = addr_valid;
      ctrl_now.h_sync      = (x_q >= HS_BEG && x_q < HS_END) ? H_POL : ~H_POL;
      ctrl_now.v_sync      = (y_q >= VS_BEG && y_q < VS_END) ? V_POL : ~V_POL;
      ctrl_now.frame_start = (x_q == '0) && (y_q == '0);
      ctrl_now.line_start  = (x_q == '0) && v_vis;
   end

   // The output register below is the final alignment stage, so the line
   // itself only has to cover the memory read latency.
   vga_delay_line #(
      .WIDTH   (CTRL_W),
      .DEPTH   (RD_LATENCY),
      .RST_VAL (CTRL_IDLE)
   ) u_ctrl_dly (
      .clk  (clk),
      .rst  (rst),
      .ce   (ce),
      .din  (ctrl_now),
      .dout (ctrl_dly)
   );

   logic [PIX_W-1:0] pix_src;

`ifdef VGA_TEST_PATTERN_EN
   localparam int unsigned BAR_W = H_VISIBLE / 8;

   if (H_VISIBLE % 8 != 0) begin : g_bad_bars
      $error("vga_display_engine: H_VISIBLE must be divisible by 8 for the test pattern");
   end

   logic [2:0]       bar_idx;
   logic [PIX_W-1:0] pat_now, pat_dly;

   always_comb begin
      bar_idx = h_vis ? 3'(x_q / XC_W'(BAR_W)) : 3'd0;
      pat_now = {{R_W{bar_idx[2]}}, {G_W{bar_idx[1]}}, {B_W{bar_idx[0]}}};
   end

   // Pattern travels the same latency as a memory read.
   vga_delay_line #(
      .WIDTH   (PIX_W),
      .DEPTH   (RD_LATENCY),
      .RST_VAL ('0)
   ) u_pat_dly (
      .clk  (clk),
      .rst  (rst),
      .ce   (ce),
      .din  (pat_now),
      .dout (pat_dly)
   );

   assign pix_src = test_en ? pat_dly : data;
`else
   assign pix_src = data;
`endif

   vga_ctrl_t        ctrl_q, ctrl_d;
   logic [PIX_W-1:0] pix_q, pix_d;

   always_comb begin
      ctrl_d = ctrl_q;
      pix_d  = pix_q;
      if (ce) begin
         ctrl_d = ctrl_dly;
         pix_d  = ctrl_dly.de ? pix_src : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q <= CTRL_IDLE;
         pix_q  <= '0;
      end else begin
         ctrl_q <= ctrl_d;
         pix_q  <= pix_d;
      end
   end

   assign de          = ctrl_q.de;
   assign h_sync      = ctrl_q.h_sync;
   assign v_sync      = ctrl_q.v_sync;
   assign frame_start = ctrl_q.frame_start;
   assign line_start  = ctrl_q.line_start;
   assign red         = pix_q[PIX_W-1 -: R_W];
   assign green       = pix_q[B_W +: G_W];
   assign blue        = pix_q[0 +: B_W];

endmodule

// File: tb/tb_vga_display_engine.sv
// Self-checking bench for vga_display_engine on a tiny 16x8 raster with a
// 2-cycle memory model; a position-based reference model checks every cycle.
`timescale 1ns/1ps
module tb_vga_display_engine;

   localparam int HV = 8, HF = 2, HS = 3, HB = 3;
   localparam int VV = 4, VF = 1, VS = 2, VB = 1;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int LAT = 2;
   localparam int X_W = 10, Y_W = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              ce  = 1'b1;
   logic [7:0]        data;
   logic [X_W+Y_W-1:0] addr;
   logic              addr_valid, h_sync, v_sync, de, frame_start, line_start;
   logic [2:0]        red, green;
   logic [1:0]        blue;
`ifdef VGA_TEST_PATTERN_EN
   logic              test_en = 1'b0;
`endif

   always #5 clk = ~clk;

   vga_display_engine #(
      .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_POL(1'b0), .V_POL(1'b0),
      .R_W(3), .G_W(3), .B_W(2),
      .RD_LATENCY(LAT), .X_W(X_W), .Y_W(Y_W)
   ) dut (
      .clk(clk), .rst(rst), .ce(ce),
`ifdef VGA_TEST_PATTERN_EN
      .test_en(test_en),
`endif
      .data(data), .addr(addr), .addr_valid(addr_valid),
      .h_sync(h_sync), .v_sync(v_sync), .de(de),
      .red(red), .green(green), .blue(blue),
      .frame_start(frame_start), .line_start(line_start)
   );

   // Memory: returns x+16*y for the address presented LAT ce-cycles earlier.
   logic [X_W+Y_W-1:0] a1 = '0, a2 = '0;
   always @(posedge clk) if (ce) begin a1 <= addr; a2 <= a1; end
   assign data = 8'(int'(a2[X_W-1:0]) + 16 * int'(a2[X_W +: Y_W]));

   // Reference model: n = ce cycles since reset release = current raster position.
   int n = 0;
   always @(posedge clk or posedge rst) begin
      if (rst) n <= 0;
      else if (ce) n <= n + 1;
   end

   int checks = 0, errors = 0;
   bit mon_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] snap();
      return {31'd0, addr, de, h_sync, v_sync, frame_start, line_start, red, green, blue};
   endfunction

   always @(negedge clk) begin : mon
      int p, cx, cy, px, py;
      logic e_av, e_de, e_hs, e_vs, e_fs, e_ls;
      logic [7:0] e_rgb;
      if (mon_en) begin
         cx   = n % HT;
         cy   = (n / HT) % VT;
         e_av = (cx < HV) && (cy < VV);
         check("addr_valid", addr_valid, e_av);
         check("addr", addr, e_av ? 64'((cy << X_W) | cx) : 64'd0);
         p = n - (LAT + 1);
         if (p < 0) begin
            e_de = 0; e_hs = 1; e_vs = 1; e_fs = 0; e_ls = 0; e_rgb = 0;
         end else begin
            px    = p % HT;
            py    = (p / HT) % VT;
            e_de  = (px < HV) && (py < VV);
            e_hs  = !(px >= HV + HF && px < HV + HF + HS);
            e_vs  = !(py >= VV + VF && py < VV + VF + VS);
            e_fs  = (px == 0) && (py == 0);
            e_ls  = (px == 0) && (py < VV);
            e_rgb = e_de ? 8'(px + 16 * py) : 8'd0;
         end
         check("de", de, e_de);
         check("h_sync", h_sync, e_hs);
         check("v_sync", v_sync, e_vs);
         check("frame_start", frame_start, e_fs);
         check("line_start", line_start, e_ls);
         check("rgb", {red, green, blue}, e_rgb);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int de_cnt, vs_low, fs_cnt, last_rise, k;
      bit prev_fs, last_ce, found;
      logic [63:0] prev_snap;

      rst = 1'b1;
      ce  = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_de", de, 0);
      check("rst_h_sync", h_sync, 1);
      check("rst_v_sync", v_sync, 1);
      check("rst_frame_start", frame_start, 0);
      check("rst_line_start", line_start, 0);
      check("rst_rgb", {red, green, blue}, 0);
      mon_en = 1'b1;

      // Directed first frame with literal expectations.
      #1 rst = 1'b0;
      #1;
      check("start_addr", addr, 0);
      check("start_addr_valid", addr_valid, 1);
      de_cnt = 0; vs_low = 0; fs_cnt = 0;
      for (int c = 1; c <= 140; c++) begin
         @(negedge clk);
         if (c == 1 || c == 2) check("early_de", de, 0);
         if (c == 3) begin
            check("first_de", de, 1);
            check("first_frame_start", frame_start, 1);
            check("first_line_start", line_start, 1);
            check("first_rgb", {red, green, blue}, 8'h00);
         end
         if (c == 19) check("line1_start", line_start, 1);
         if (c == 21) check("addr_l1_p5", addr, {10'd1, 10'd5});
         if (c == 24) check("rgb_l1_p5", {red, green, blue}, 8'h15);
         if (c == 12 || c == 16) check("h_sync_idle", h_sync, 1);
         if (c >= 13 && c <= 15) check("h_sync_active", h_sync, 0);
         if (c >= 3 && c < 131) begin
            de_cnt += int'(de);
            vs_low += int'(!v_sync);
            fs_cnt += int'(frame_start);
         end
         if (c == 131) check("second_frame_start", frame_start, 1);
      end
      check("de_per_frame", de_cnt, 32);
      check("v_sync_low_per_frame", vs_low, 32);
      check("frame_start_per_frame", fs_cnt, 1);

      // ce toggling 1/0: outputs hold, frame period doubles.
      last_rise = -1; prev_fs = frame_start; last_ce = ce; prev_snap = snap();
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         if (!last_ce) check("hold_ce0", snap(), prev_snap);
         if (frame_start && !prev_fs) begin
            if (last_rise >= 0) check("frame_period_ce_half", c - last_rise, 256);
            last_rise = c;
         end
         prev_fs   = frame_start;
         prev_snap = snap();
         #1 ce = (c % 2 == 0) ? 1'b0 : 1'b1;
         last_ce = ce;
      end

      // Random clock enable against the model.
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         #1 ce = ($urandom_range(0, 3) != 0);
      end

      // Reset mid-frame at x=6, y=2.
      ce = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 300 && !found; c++) begin
         @(negedge clk);
         if (n % (HT * VT) == 2 * HT + 6) found = 1'b1;
      end
      check("reach_x6_y2", found, 1);
      #1 rst = 1'b1;
      #1;
      check("midrst_de", de, 0);
      check("midrst_frame_start", frame_start, 0);
      check("midrst_line_start", line_start, 0);
      check("midrst_h_sync", h_sync, 1);
      check("midrst_v_sync", v_sync, 1);
      check("midrst_rgb", {red, green, blue}, 0);
      check("midrst_addr", addr, 0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      for (k = 1; k <= 3; k++) begin
         @(negedge clk);
         check("post_rst_frame_start", frame_start, (k == 3) ? 1 : 0);
      end

      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         #1 ce = ($urandom_range(0, 1) != 0);
      end
      ce = 1'b1;

`ifdef VGA_TEST_PATTERN_EN
      mon_en  = 1'b0;
      @(negedge clk);
      #1 test_en = 1'b1;
      repeat (5) @(negedge clk);
      found = 1'b0;
      for (int c = 0; c < 300 && !found; c++) begin
         @(negedge clk);
         if (frame_start) found = 1'b1;
      end
      check("pattern_frame_start", found, 1);
      for (int px = 0; px < HV; px++) begin : pat
         logic [2:0] kb;
         kb = 3'(px);
         check("pattern_bar", {red, green, blue}, {{3{kb[2]}}, {3{kb[1]}}, {2{kb[0]}}});
         @(negedge clk);
      end
      #1 test_en = 1'b0;
`endif

      mon_en = 1'b0;
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
